free_keys: RTL

Input stage for free-play mode. It feeds free_tubs and the tone generator.
- Synchronises and debounces 7 note switches and 2 octave buttons.
- Priority-encodes the pressed note to 3 bits.
- Tracks the current octave (lo/mi/hi) with a small state machine.
- Its outputs state[1:0] and note[2:0] connect directly to free_tubs' state and note inputs.

---
 rtl/free_keys_pkg.sv | 13 +
 rtl/free_keys_debounce.sv | 36 +++
 rtl/free_keys.sv | 109 ++++++++++
 3 files changed

// File: rtl/free_keys_pkg.sv
// Shared octave codes for the free-play input stage.
// free_tubs decodes the same octave encoding.
package free_keys_pkg;

   typedef logic [1:0] oct_t;

   localparam oct_t OCT_LO = 2'd0;
   localparam oct_t OCT_MI = 2'd1;
   localparam oct_t OCT_HI = 2'd2;

   localparam int NUM_KEYS = 7;

endpackage

// File: rtl/free_keys_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// The debounced level flips only after DB_CYCLES consecutive differing cycles.
module key_debounce #(
   parameter int DB_CYCLES = 200000,
   parameter int CNT_W     = 18
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] != level) begin
            if (cnt == CNT_W'(DB_CYCLES - 1)) begin
               level <= ~level;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/free_keys.sv
// Free-play input stage: debounced keys, note encoder, octave FSM.
// Build option OCTAVE_WRAP_EN makes octave stepping wrap instead of saturate.
module free_keys
   import free_keys_pkg::*;
#(
   parameter int DB_CYCLES = 200000,
   parameter int CNT_W     = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [6:0] key_raw,
   input  logic       oct_up_raw,
   input  logic       oct_dn_raw,
   output logic [1:0] state,
   output logic [2:0] note,
   output logic       note_on
);

   logic [8:0] raw_all;
   logic [8:0] lvl;

   assign raw_all = {oct_dn_raw, oct_up_raw, key_raw};

   for (genvar g = 0; g < 9; g++) begin : g_db
      key_debounce #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_all[g]),
         .level (lvl[g])
      );
   end

   logic [NUM_KEYS-1:0] keys;
   logic                up_lvl;
   logic                dn_lvl;
   logic                up_q;
   logic                dn_q;
   logic                up_ev;
   logic                dn_ev;

   assign keys   = lvl[6:0];
   assign up_lvl = lvl[7];
   assign dn_lvl = lvl[8];
   assign up_ev  = up_lvl & ~up_q;
   assign dn_ev  = dn_lvl & ~dn_q;

   oct_t state_nxt;

   always_comb begin
      state_nxt = state;
      if (en && up_ev && !dn_ev) begin
         unique case (state)
            OCT_LO:  state_nxt = OCT_MI;
            OCT_MI:  state_nxt = OCT_HI;
`ifdef OCTAVE_WRAP_EN
            OCT_HI:  state_nxt = OCT_LO;
`else
            OCT_HI:  state_nxt = OCT_HI;
`endif
            default: state_nxt = OCT_MI;
         endcase
      end else if (en && dn_ev && !up_ev) begin
         unique case (state)
            OCT_HI:  state_nxt = OCT_MI;
            OCT_MI:  state_nxt = OCT_LO;
`ifdef OCTAVE_WRAP_EN
            OCT_LO:  state_nxt = OCT_HI;
`else
            OCT_LO:  state_nxt = OCT_LO;
`endif
            default: state_nxt = OCT_MI;
         endcase
      end
   end

   logic [2:0] enc;
   logic [2:0] note_nxt;

   // Scan high to low so the lowest pressed key is written last and wins.
   always_comb begin
      enc = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (keys[i]) enc = 3'(i + 1);
      end
   end

   assign note_nxt = en ? enc : 3'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= OCT_MI;
         note    <= '0;
         note_on <= 1'b0;
         up_q    <= 1'b0;
         dn_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         note    <= note_nxt;
         note_on <= (note_nxt != 3'd0) && (note_nxt != note);
         up_q    <= up_lvl;
         dn_q    <= dn_lvl;
      end
   end

endmodule
